pcileech_tx_arbiter: RTL
========================

// Module: pcileech_tx_arbiter
//
// PURPOSE
//  Packet-aware round-robin arbiter that shares the single PCIe->FT601 return path
//  between the TLP RX stream and the CFG RX stream inside the FIFO layer.
//  Once a source wins, it holds the grant until the beat flagged *_last is accepted.
//  A starvation watchdog frees the path if the locked source stops supplying beats.
//  The output is registered and tagged with its source ID for the FT601 framer.
//
// PARAMETERS
//  TIMEOUT_CYCLES  1024  consecutive cycles of locked-source valid=0 before abort (>=2)
//  ERRCNT_W        16    width of err_count (saturating)
//
// PORTS
//  CLK          in   1    PCIe user clock; sole clock
//  RESET        in   1    asynchronous, active-high reset
//  tlp_data     in   64   TLP source data word
//  tlp_last     in   1    final word of TLP packet
//  tlp_valid    in   1    TLP word available
//  tlp_ready    out  1    TLP word accepted this cycle when tlp_valid=1
//  cfg_data     in   64   CFG source data word
//  cfg_last     in   1    final word of CFG packet
//  cfg_valid    in   1    CFG word available
//  cfg_ready    out  1    CFG word accepted this cycle when cfg_valid=1
//  out_data     out  64   registered output word
//  out_src      out  1    0 = TLP, 1 = CFG
//  out_last     out  1    registered copy of the source's last flag
//  out_valid    out  1    output word valid
//  out_ready    in   1    downstream accepts the output word
//  busy         out  1    1 while in LOCK_TLP or LOCK_CFG
//  err_timeout  out  1    one-cycle pulse on watchdog abort
//  err_count    out  ERRCNT_W  watchdog abort count; saturates at all-ones
//
// BEHAVIOUR
//  Reset
//  - All outputs 0; state IDLE; rr_ptr=1 (CFG preferred first); watchdog cnt=0.
//
//  Output register
//  - load = out_ready | ~out_valid.
//  - A source beat transfers when (src_valid & src_ready). src_ready = grant & load.
//  - On transfer, out_* <= {src data, src id, src last} and out_valid <= 1 next cycle.
//  - Otherwise, if out_ready, out_valid <= 0.
//  - Latency is 1 cycle. Full throughput: 1 beat/cycle when out_ready is held at 1.
//
//  Grant
//  - IDLE: grant goes to the valid source. If both are valid, grant goes to the
//    rr_ptr side (1=CFG, 0=TLP). Grant is combinational, so the first beat can
//    transfer in the same cycle.
//      . Transferred beat has last=1: stay in IDLE; rr_ptr <= ~winner.
//      . Transferred beat has last=0: go to LOCK_<winner>; cnt <= 0.
//  - LOCK_x: only source x may be ready.
//      . The other source is never granted mid-packet.
//      . Beat of x transferred with last=1: go to IDLE; rr_ptr <= ~x; cnt <= 0.
//  - In IDLE with no valid source: no grant; rr_ptr unchanged.
//
//  Watchdog (LOCK states only)
//  - cnt increments on a cycle where x_valid=0.
//  - cnt clears on a transferred beat.
//  - cnt holds while x_valid=1 and the path is blocked by downstream backpressure.
//  - When cnt == TIMEOUT_CYCLES-1 and x_valid=0:
//      . go to IDLE; rr_ptr <= ~x;
//      . err_timeout=1 for 1 cycle; err_count+1 (saturating).
//  - The already-sent partial packet is not retracted.
//  - The next beat from x is treated as the start of a new packet.
//  - Simultaneous timeout and x_valid=1: the beat wins (transfer, no abort).
//
//  Other
//  - RESET asserted mid-packet returns to the reset state immediately. out_valid drops;
//    an in-flight output word is lost.
//  - out_* hold stable while out_valid=1 and out_ready=0.
//
// TESTING
//  1. Both valid at once after reset, 1-beat packets each -> CFG beat first, then TLP,
//     then CFG; out_src sequence 1,0,1; one beat per cycle.
//  2. TLP 4-beat packet with cfg_valid held high throughout -> all 4 TLP beats
//     back-to-back; cfg_ready=0 until tlp_last is accepted; CFG word appears on
//     cycle 5 of output.
//  3. out_ready toggled 1,0,0,1 during a 3-beat CFG packet -> no beat lost or
//     duplicated; out_data stable while stalled; watchdog cnt stays 0.
//  4. TLP sends 1 beat with last=0, then tlp_valid=0 for TIMEOUT_CYCLES cycles ->
//     err_timeout pulses once on cycle 1024 of starvation; err_count=1; busy=0;
//     a waiting CFG packet is granted next.
//  5. RESET asserted on beat 2 of a 4-beat packet -> out_valid=0, busy=0,
//     err_count=0; after release, both sources valid -> CFG granted first.
//  6. Force err_count to all-ones (ERRCNT_W=2: 3 aborts), then cause another abort
//     -> err_count stays 3; err_timeout still pulses.

Source files
------------

// File: rtl/pcileech_tx_arbiter.sv
// Packet-aware round-robin arbiter: TLP and CFG streams onto one output.
// Grant locks per packet; a watchdog releases a starved lock.
module pcileech_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ERRCNT_W       = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [63:0]         tlp_data,
  input  logic                tlp_last,
  input  logic                tlp_valid,
  output logic                tlp_ready,
  input  logic [63:0]         cfg_data,
  input  logic                cfg_last,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [63:0]         out_data,
  output logic                out_src,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                err_timeout,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOCK_TLP,
    LOCK_CFG
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             rr_ptr;
  logic             rr_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             abort;
  logic             gnt_tlp;
  logic             gnt_cfg;
  logic             load;
  logic             xfer_tlp;
  logic             xfer_cfg;
  logic             lk_id;
  logic             lk_valid;
  logic             lk_last;
  logic             lk_xfer;

  assign load      = out_ready | ~out_valid;
  assign tlp_ready = gnt_tlp & load;
  assign cfg_ready = gnt_cfg & load;
  assign xfer_tlp  = tlp_valid & tlp_ready;
  assign xfer_cfg  = cfg_valid & cfg_ready;
  assign busy      = (state != IDLE);

  assign lk_id    = (state == LOCK_CFG);
  assign lk_valid = lk_id ? cfg_valid : tlp_valid;
  assign lk_last  = lk_id ? cfg_last : tlp_last;
  assign lk_xfer  = lk_id ? xfer_cfg : xfer_tlp;

  // rr_ptr breaks ties only; a lone valid source always wins
  always_comb begin
    gnt_tlp = 1'b0;
    gnt_cfg = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_tlp = tlp_valid & (~cfg_valid | ~rr_ptr);
        gnt_cfg = cfg_valid & (~tlp_valid | rr_ptr);
      end
      LOCK_TLP: gnt_tlp = 1'b1;
      LOCK_CFG: gnt_cfg = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    cnt_n   = cnt;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer_tlp) begin
          if (tlp_last) begin
            rr_n = 1'b1;
          end else begin
            state_n = LOCK_TLP;
            cnt_n   = '0;
          end
        end else if (xfer_cfg) begin
          if (cfg_last) begin
            rr_n = 1'b0;
          end else begin
            state_n = LOCK_CFG;
            cnt_n   = '0;
          end
        end
      end
      LOCK_TLP, LOCK_CFG: begin
        if (lk_xfer) begin
          cnt_n = '0;
          if (lk_last) begin
            state_n = IDLE;
            rr_n    = ~lk_id;
          end
        end else if (!lk_valid) begin
          if (cnt == CNT_MAX) begin
            state_n = IDLE;
            rr_n    = ~lk_id;
            cnt_n   = '0;
            abort   = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      rr_ptr      <= 1'b1;
      cnt         <= '0;
      err_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_n;
      cnt         <= cnt_n;
      err_timeout <= abort;
      if (abort && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_data  <= '0;
      out_src   <= 1'b0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (xfer_tlp || xfer_cfg) begin
      out_data  <= xfer_cfg ? cfg_data : tlp_data;
      out_src   <= xfer_cfg;
      out_last  <= xfer_cfg ? cfg_last : tlp_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
